// File: rtl/spi_seq_pkg.sv
// SPI transaction sequencer shared types.
// Entry layout and FSM state encoding.
package spi_seq_pkg;

  localparam int ENTRY_W = 10;
  localparam int DC_BIT  = 9;
  localparam int END_BIT = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Entry FIFO for the SPI sequencer.
// Pointers reset; storage does not.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic [LW-1:0]      level,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & (level != '0) & ~flush;
  assign head    = mem[rp];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queued byte sequencer in front of spi_ctrl.
// Launches FIFO entries and captures rx bytes.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               flush,
  output logic               full,
  output logic [LW-1:0]      level,
  output logic               idle,
  output logic               overflow,
  output logic               spi_start,
  output logic               spi_dc,
  output logic               spi_end_txn,
  output logic [7:0]         spi_data,
  input  logic               spi_busy,
  input  logic [7:0]         spi_rx_data,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_read,
  output logic               rx_overrun
);

  state_t             state;
  state_t             nxt;
  logic               pop;
  logic               cap;
  logic               has;
  logic [ENTRY_W-1:0] head;

  spi_seq_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .level (level),
    .full  (full)
  );

  assign has       = (level != '0) & ~flush;
  assign spi_start = (state == S_LAUNCH);
  assign idle      = (level == '0) & (state == S_IDLE) & ~spi_busy;

  // Next-state, pop and capture decode.
  always_comb begin
    nxt = state;
    pop = 1'b0;
    cap = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (has && !spi_busy) begin
          nxt = S_LAUNCH;
          pop = 1'b1;
        end
      end
      S_LAUNCH: nxt = S_SETTLE;
      S_SETTLE: nxt = S_WAIT;
      S_WAIT: begin
        if (!spi_busy) begin
          cap = 1'b1;
          if (has) begin
            nxt = S_LAUNCH;
            pop = 1'b1;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
    endcase
  end

  // State and launch output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      spi_dc      <= 1'b0;
      spi_end_txn <= 1'b0;
      spi_data    <= '0;
    end else begin
      state <= nxt;
      if (pop) begin
        spi_dc      <= head[DC_BIT];
        spi_end_txn <= head[END_BIT];
        spi_data    <= head[7:0];
      end
    end
  end

  // Rx capture and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (cap) begin
        rx_data  <= spi_rx_data;
        rx_valid <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end
      if (flush) begin
        rx_overrun <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (cap && rx_valid && !rx_read) rx_overrun <= 1'b1;
        if (wr_en && full)               overflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Scoreboard bench for spi_txn_sequencer.
// Behavioural spi_ctrl model drives busy/rx.
module tb_spi_txn_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 0;
  logic          rstn = 0;
  logic          wr_en = 0;
  logic [9:0]    wr_data = '0;
  logic          flush = 0;
  logic          full;
  logic [LW-1:0] level;
  logic          idle;
  logic          overflow;
  logic          spi_start;
  logic          spi_dc;
  logic          spi_end_txn;
  logic [7:0]    spi_data;
  logic          spi_busy;
  logic [7:0]    spi_rx_data;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_read = 1;
  logic          rx_overrun;

  logic          m_busy;
  logic          force_busy = 0;
  logic          seen;
  logic          fell;
  logic          cap_due;
  int            cnt;
  int            bt = 8;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            push_cyc = 0;

  logic [9:0]    exp_tx[$];
  logic [7:0]    exp_rx[$];
  int            starts_q[$];

  assign spi_busy = m_busy | force_busy;

  spi_txn_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .full        (full),
    .level       (level),
    .idle        (idle),
    .overflow    (overflow),
    .spi_start   (spi_start),
    .spi_dc      (spi_dc),
    .spi_end_txn (spi_end_txn),
    .spi_data    (spi_data),
    .spi_busy    (spi_busy),
    .spi_rx_data (spi_rx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_read     (rx_read),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // spi_ctrl model: busy one cycle after start, for bt cycles.
  always @(posedge clk or negedge rstn) begin
    logic [7:0] rxb;
    if (!rstn) begin
      m_busy      <= 0;
      seen        <= 0;
      fell        <= 0;
      cap_due     <= 0;
      cnt         <= 0;
      spi_rx_data <= '0;
    end else begin
      fell    <= 0;
      cap_due <= fell;
      if (seen) begin
        m_busy <= 1;
        cnt    <= bt;
        seen   <= 0;
      end else if (m_busy) begin
        if (cnt == 1) begin
          m_busy <= 0;
          fell   <= 1;
          rxb = 8'($urandom);
          spi_rx_data <= rxb;
          exp_rx.push_back(rxb);
        end
        cnt <= cnt - 1;
      end
      if (spi_start) seen <= 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares launches and captures against queues.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [7:0] r;
    if (rstn) begin
      if (spi_start) begin
        starts_q.push_back(cyc);
        if (exp_tx.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_tx.pop_front();
          chk("launch_entry",
              {22'd0, spi_dc, spi_end_txn, spi_data},
              {22'd0, e});
        end
      end
      if (cap_due) begin
        if (exp_rx.size() == 0) begin
          chk("unexpected_cap", 1, 0);
        end else begin
          r = exp_rx.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, r});
          chk("rx_valid_cap", {31'd0, rx_valid}, 1);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] e);
    wr_en   = 1;
    wr_data = e;
    push_cyc = cyc;
    if (exp_tx.size() < DEPTH && !flush) exp_tx.push_back(e);
    tick();
    wr_en = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(idle && exp_tx.size() == 0 && !cap_due) && n < 2000);
    chk("idle_timeout", {31'd0, n < 2000}, 1);
  endtask

  task automatic wait_fell();
    int n = 0;
    while (!fell && n < 2000) begin
      tick();
      n++;
    end
    chk("fell_timeout", {31'd0, n < 2000}, 1);
  endtask

  initial begin
    int n;
    logic [9:0] e;

    // Reset state
    #12;
    chk("rst_outs",
        {9'd0, full, overflow, spi_start, spi_dc,
         spi_end_txn, spi_data, rx_data, rx_valid, rx_overrun},
        0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_idle", {31'd0, idle}, 1);
    rstn = 1;
    tick();

    // Single entry latency
    bt = 8;
    starts_q.delete();
    push(10'h2A5);
    wait_idle();
    chk("t1_starts", starts_q.size(), 1);
    if (starts_q.size() > 0)
      chk("t1_latency", starts_q[0] - push_cyc, 2);
    chk("t1_idle", {31'd0, idle}, 1);

    // Fill, overflow, ordered back-to-back launches
    bt = $urandom_range(2, 9);
    force_busy = 1;
    tick();
    for (int i = 0; i < 4; i++) push(10'($urandom));
    chk("t2_level4", {29'd0, level}, 4);
    chk("t2_full", {31'd0, full}, 1);
    push(10'($urandom));
    chk("t2_level_ovf", {29'd0, level}, 4);
    chk("t2_overflow", {31'd0, overflow}, 1);
    starts_q.delete();
    force_busy = 0;
    wait_idle();
    chk("t2_starts", starts_q.size(), 4);
    for (int i = 1; i < starts_q.size(); i++)
      chk("t2_spacing", starts_q[i] - starts_q[i-1], bt + 3);

    // Push and pop on the same edge at level 2
    bt = $urandom_range(2, 6);
    force_busy = 1;
    tick();
    push(10'($urandom));
    push(10'($urandom));
    force_busy = 0;
    push(10'($urandom));
    chk("t3_level_a", {29'd0, level}, 2);
    for (int i = 0; i < 5; i++) begin
      wait_fell();
      push(10'($urandom));
      chk("t3_level_b", {29'd0, level}, 2);
    end
    starts_q.delete();
    wait_idle();
    chk("t3_drain", starts_q.size(), 2);

    // Flush with write during WAIT
    chk("t4_ovf_pre", {31'd0, overflow}, 1);
    bt = $urandom_range(3, 8);
    force_busy = 1;
    tick();
    for (int i = 0; i < 3; i++) push(10'($urandom));
    starts_q.delete();
    force_busy = 0;
    n = 0;
    while (!m_busy && n < 100) begin
      tick();
      n++;
    end
    chk("t4_busy_to", {31'd0, n < 100}, 1);
    flush   = 1;
    wr_en   = 1;
    wr_data = 10'($urandom);
    exp_tx.delete();
    tick();
    flush = 0;
    wr_en = 0;
    chk("t4_level", {29'd0, level}, 0);
    chk("t4_overflow", {31'd0, overflow}, 0);
    wait_idle();
    repeat (20) tick();
    chk("t4_starts", starts_q.size(), 1);

    // Rx overrun, then read on capture edge
    rx_read = 0;
    bt = $urandom_range(2, 6);
    push(10'($urandom));
    push(10'($urandom));
    wait_idle();
    chk("t5_overrun", {31'd0, rx_overrun}, 1);
    chk("t5_valid", {31'd0, rx_valid}, 1);
    flush = 1;
    tick();
    flush = 0;
    chk("t5_ovr_clr", {31'd0, rx_overrun}, 0);
    push(10'($urandom));
    wait_fell();
    rx_read = 1;
    tick();
    rx_read = 0;
    chk("t5_valid_rd", {31'd0, rx_valid}, 1);
    chk("t5_no_ovr", {31'd0, rx_overrun}, 0);
    rx_read = 1;
    tick();
    chk("t5_valid_clr", {31'd0, rx_valid}, 0);

    // Reset during SETTLE
    bt = 8;
    e = 10'($urandom);
    push(e);
    n = 0;
    while (!spi_start && n < 100) begin
      tick();
      n++;
    end
    chk("t6_start_to", {31'd0, n < 100}, 1);
    tick();
    rstn = 0;
    #1;
    chk("t6_outs",
        {9'd0, full, overflow, spi_start, spi_dc,
         spi_end_txn, spi_data, rx_data, rx_valid, rx_overrun},
        0);
    chk("t6_idle", {31'd0, idle}, 1);
    exp_rx.delete();
    exp_tx.delete();
    tick();
    rstn = 1;
    repeat (3) tick();
    chk("t6_level", {29'd0, level}, 0);
    chk("t6_idle_post", {31'd0, idle}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Queued transaction sequencer that sits between the CPU peripheral write path and `spi_ctrl`. Software pushes byte entries (data, DC, end-of-transaction flag) into a small FIFO; the sequencer launches each entry with a `start` pulse, waits for `busy` to drop, then captures the received byte. This lets the CPU stream display or flash data without polling the SPI status register for every byte.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, at least 2.
- `LW`, $clog2(DEPTH)+1: width of the `level` output.

Ports:
- `clk`, in, 1: single clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: push one entry.
- `wr_data`, in, 10: entry as {dc[9], end_txn[8], byte[7:0]}.
- `flush`, in, 1: empty the FIFO and clear the sticky flags.
- `full`, out, 1: FIFO full.
- `level`, out, LW: number of queued entries.
- `idle`, out, 1: FIFO empty, FSM in IDLE and `spi_busy` low.
- `overflow`, out, 1: sticky; a push was attempted while the FIFO was full.
- `spi_start`, out, 1: one-cycle launch pulse to `spi_ctrl`.
- `spi_dc`, out, 1: DC bit for `spi_ctrl`.
- `spi_end_txn`, out, 1: end-of-transaction bit for `spi_ctrl`.
- `spi_data`, out, 8: byte for `spi_ctrl`.
- `spi_busy`, in, 1: busy from `spi_ctrl`.
- `spi_rx_data`, in, 8: `data_out` from `spi_ctrl`.
- `rx_data`, out, 8: last received byte.
- `rx_valid`, out, 1: `rx_data` is unread.
- `rx_read`, in, 1: consume `rx_data`.
- `rx_overrun`, out, 1: sticky; a captured byte overwrote an unread one.

## Operation
- Reset value of every output is 0, except `idle`, which resets to 1. The FSM resets to IDLE and the FIFO resets empty.
- FSM states: IDLE, LAUNCH, SETTLE, WAIT.
  - IDLE: if `level` > 0 and `spi_busy` = 0, go to LAUNCH. On that edge, pop the head entry and load it into `spi_dc`/`spi_end_txn`/`spi_data`.
  - LAUNCH: `spi_start` = 1 for this cycle only. Go to SETTLE.
  - SETTLE: ignore `spi_busy`, which `spi_ctrl` raises one cycle after it samples `start`. Go to WAIT.
  - WAIT: stay while `spi_busy` = 1. When `spi_busy` is sampled low, capture `spi_rx_data` into `rx_data` and set `rx_valid`. If `level` > 0, go to LAUNCH with a pop and load on the same edge; otherwise go to IDLE.
- `spi_dc`, `spi_end_txn` and `spi_data` are registered and hold their value until the next load.
- Push while full: entry dropped, `overflow` set, `level` unchanged.
- Push and pop on the same edge: allowed at any level below full. `level` is unchanged. When `level` = 0, a push cannot pop on the same edge.
- Pointers wrap modulo DEPTH.
- `level` ranges 0..DEPTH. `full` = (`level` == DEPTH).
- `flush`:
  - Sets `level` to 0 and clears `overflow` and `rx_overrun`.
  - Wins over a simultaneous `wr_en`; the write is discarded and does not set `overflow`.
  - Does not abort an in-flight byte. LAUNCH/SETTLE/WAIT complete normally and capture rx; that entry was already popped.
- `rx_read` clears `rx_valid`.
- Capture and `rx_read` on the same edge: new data, `rx_valid` stays 1, no overrun.
- Capture while `rx_valid` = 1 and no `rx_read`: data overwritten, `rx_overrun` set.
- Reset asserted mid-transaction: all state clears immediately. `spi_ctrl` shares `rstn`, so no half-sent byte is left pending.

## Timing
- `wr_en` sampled at edge E0 makes `level` = 1 after E0.
- IDLE transitions at E1. `spi_start` is high between E1 and E2, with data already stable on the outputs.
- Push-to-launch latency is 2 cycles.
- Back-to-back entries: next `spi_start` comes 1 cycle after the edge where `busy` is sampled low. Per-byte overhead is 3 cycles beyond `spi_ctrl` busy time.
- `rx_valid` rises on the same edge that leaves WAIT.
- `idle` is combinational from registered state and `spi_busy`.

## Structure
- Package `spi_seq_pkg`:
  - state enum (IDLE, LAUNCH, SETTLE, WAIT);
  - `ENTRY_W` = 10;
  - bit positions `DC_BIT` = 9, `END_BIT` = 8.
- Sub-module `spi_seq_fifo`: parameterised synchronous FIFO, width ENTRY_W.
  - Ports: push, pop, flush, head, level, full.
  - Asynchronous active-low reset on pointers only; storage is not reset.
- Top level: FSM, output registers, rx capture and sticky flags.

## Test plan
- Reset, then push 0x2A5 while `spi_busy` tied to a model with 8-cycle busy. Required:
  - `spi_start` pulses exactly 2 cycles after the push, with `spi_dc`=1, `spi_end_txn`=0, `spi_data`=0xA5;
  - `rx_data` equals the model's return byte when busy falls;
  - `idle`=1 afterwards.
- Push 4 entries back-to-back (DEPTH=4). Required:
  - `full`=1 after the fourth push;
  - a fifth push sets `overflow`, and `level` stays 4;
  - 4 launches occur in push order;
  - consecutive `spi_start` pulses are separated by busy time + 3 cycles.
- Push and pop on the same edge at `level`=2 → `level` stays 2, and no entry is lost or duplicated across 8 bytes.
- `flush` together with `wr_en` during WAIT. Required:
  - `level`=0 and `overflow` cleared;
  - the in-flight byte still completes and is captured;
  - no further `spi_start` occurs.
- Two bytes captured without `rx_read` → `rx_overrun`=1 and `rx_data` = second byte. Then `rx_read` on the same edge as a third capture → `rx_valid` stays 1.
- Assert `rstn` low during SETTLE → all outputs 0 and `idle`=1 immediately; the FIFO is empty after release.
